// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    BYTE,
    HWRD,
    WORD
  } acc_size_t;

  // Byte-lane enables for a store of the given size at the given byte offset.
  function automatic logic [3:0] lane_enables(input acc_size_t size, input logic [1:0] offset);
    logic [3:0] be;
    case (size)
      BYTE:    be = 4'b0001 << offset;
      HWRD:    be = offset[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Pipeline memory-stage request/response bundle for the data memory.
interface dmem_if;
  logic [31:0] i_dmem_addr;
  logic [31:0] i_dmem_wdata;
  logic        i_dmem_write;
  logic        i_dmem_read;
  logic        i_dmem_rdu;
  logic        i_dmem_byte;
  logic        i_dmem_hwrd;
  logic [31:0] o_dmem_rdata;
  logic        o_dmem_stall;
  logic        o_dmem_err;

  modport master (
    output i_dmem_addr, i_dmem_wdata, i_dmem_write, i_dmem_read,
           i_dmem_rdu, i_dmem_byte, i_dmem_hwrd,
    input  o_dmem_rdata, o_dmem_stall, o_dmem_err
  );

  modport slave (
    input  i_dmem_addr, i_dmem_wdata, i_dmem_write, i_dmem_read,
           i_dmem_rdu, i_dmem_byte, i_dmem_hwrd,
    output o_dmem_rdata, o_dmem_stall, o_dmem_err
  );
endinterface

// File: rtl/dmem_ram.sv
// Single-port word-wide storage with byte-lane write enables,
// synchronous write and registered (synchronous) read.
module dmem_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  input  logic          re,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Lane-masked write and registered read; contents are never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: stores commit in one cycle without stalling,
// loads stall for READ_WAIT+1 cycles and present extended data in DONE.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int READ_WAIT   = 1
) (
  input logic   i_clk,
  input logic   i_rst,
  dmem_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = (READ_WAIT > 0) ? 4'(READ_WAIT - 1) : 4'd0;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  acc_size_t   size;
  logic        misaligned;
  logic        req_err;
  logic        load_ok;
  logic        store_ok;
  logic        ram_re;
  logic [31:0] ram_q;
  logic [31:0] wdata_rep;
  logic [31:0] load_val;
  logic [31:0] rdata_q;
  logic        unused_addr;

  assign unused_addr = ^bus.i_dmem_addr[31:AW+2];

  // Sign- or zero-extend the addressed lane of a fetched word.
  function automatic logic [31:0] extend_load(input logic [31:0] word, input acc_size_t sz,
                                              input logic [1:0] offset, input logic zext);
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic signed [31:0] ext;
    b_s = word[8*offset +: 8];
    h_s = offset[1] ? word[31:16] : word[15:0];
    case (sz)
      BYTE:    ext = zext ? {24'd0, b_s} : 32'(b_s);
      HWRD:    ext = zext ? {16'd0, h_s} : 32'(h_s);
      default: ext = word;
    endcase
    return ext;
  endfunction

  // Decode access size (byte wins over halfword) and request legality.
  always_comb begin
    size = WORD;
    if (bus.i_dmem_byte)      size = BYTE;
    else if (bus.i_dmem_hwrd) size = HWRD;
    misaligned = ((size == HWRD) && bus.i_dmem_addr[0]) ||
                 ((size == WORD) && (bus.i_dmem_addr[1:0] != 2'b00));
    req_err  = (state == IDLE) &&
               ((bus.i_dmem_read && bus.i_dmem_write) ||
                ((bus.i_dmem_read || bus.i_dmem_write) && misaligned));
    load_ok  = (state == IDLE) && bus.i_dmem_read && !bus.i_dmem_write && !misaligned;
    store_ok = (state == IDLE) && bus.i_dmem_write && !bus.i_dmem_read && !misaligned;
    case (size)
      BYTE:    wdata_rep = {4{bus.i_dmem_wdata[7:0]}};
      HWRD:    wdata_rep = {2{bus.i_dmem_wdata[15:0]}};
      default: wdata_rep = bus.i_dmem_wdata;
    endcase
  end

  // Next-state and wait-counter logic; the array is read on the edge entering DONE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ram_re    = 1'b0;
    case (state)
      IDLE: begin
        if (load_ok) begin
          if (READ_WAIT > 0) begin
            state_nxt = WAIT;
            cnt_nxt   = WAIT_INIT;
          end else begin
            state_nxt = DONE;
            ram_re    = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = DONE;
          ram_re    = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State and counter registers; reset aborts any load in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  dmem_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .clk  (i_clk),
    .addr (bus.i_dmem_addr[AW+1:2]),
    .we   (store_ok && !i_rst),
    .be   (lane_enables(size, bus.i_dmem_addr[1:0])),
    .wdata(wdata_rep),
    .re   (ram_re),
    .rdata(ram_q)
  );

  assign load_val = extend_load(ram_q, size, bus.i_dmem_addr[1:0], bus.i_dmem_rdu);

  // Hold the last delivered load value so rdata is stable outside DONE.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)              rdata_q <= 32'd0;
    else if (state == DONE) rdata_q <= load_val;
  end

  assign bus.o_dmem_rdata = (state == DONE) ? load_val : rdata_q;
  assign bus.o_dmem_stall = !i_rst && (load_ok || (state == WAIT));
  assign bus.o_dmem_err   = req_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance with READ_WAIT=1 and
// one with READ_WAIT=0, driven one at a time through a shared request set.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic [31:0] addr, wdata;
  logic        wr, rd, rdu, bt, hw;

  always #5 clk = ~clk;

  dmem_if bus0 ();
  dmem_if bus1 ();

  assign bus0.i_dmem_addr  = addr;
  assign bus0.i_dmem_wdata = wdata;
  assign bus0.i_dmem_write = wr & ~sel;
  assign bus0.i_dmem_read  = rd & ~sel;
  assign bus0.i_dmem_rdu   = rdu;
  assign bus0.i_dmem_byte  = bt;
  assign bus0.i_dmem_hwrd  = hw;
  assign bus1.i_dmem_addr  = addr;
  assign bus1.i_dmem_wdata = wdata;
  assign bus1.i_dmem_write = wr & sel;
  assign bus1.i_dmem_read  = rd & sel;
  assign bus1.i_dmem_rdu   = rdu;
  assign bus1.i_dmem_byte  = bt;
  assign bus1.i_dmem_hwrd  = hw;

  dmem_responder #(.DEPTH_WORDS(1024), .READ_WAIT(1)) dut0 (
    .i_clk(clk), .i_rst(rst), .bus(bus0.slave)
  );
  dmem_responder #(.DEPTH_WORDS(64), .READ_WAIT(0)) dut1 (
    .i_clk(clk), .i_rst(rst), .bus(bus1.slave)
  );

  wire [31:0] m_rdata = sel ? bus1.o_dmem_rdata : bus0.o_dmem_rdata;
  wire        m_stall = sel ? bus1.o_dmem_stall : bus0.o_dmem_stall;
  wire        m_err   = sel ? bus1.o_dmem_err   : bus0.o_dmem_err;

  typedef struct {
    logic [31:0] data;
    int          stall;
    int          id;
  } exp_t;

  exp_t        sbq[$];
  int          errors = 0;
  int          checks = 0;
  int          load_id = 0;
  logic [31:0] last_exp = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic set_req(input logic [31:0] a, input logic [31:0] d, input logic w,
                         input logic r, input logic b, input logic h, input logic u);
    @(posedge clk);
    #1;
    addr = a; wdata = d; wr = w; rd = r; bt = b; hw = h; rdu = u;
  endtask

  task automatic idle();
    set_req(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic b, input logic h);
    set_req(a, d, 1'b1, 1'b0, b, h, 1'b0);
    #1;
    check("store_stall", 32'(m_stall), 32'd0);
    check("store_err", 32'(m_err), 32'd0);
  endtask

  task automatic load(input logic [31:0] a, input logic b, input logic h, input logic u,
                      input logic [31:0] exp, input int st);
    int n;
    set_req(a, 32'd0, 1'b0, 1'b1, b, h, u);
    sbq.push_back('{data: exp, stall: st, id: load_id});
    load_id++;
    last_exp = exp;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (m_stall && n < 20);
    if (m_stall) begin
      checks++;
      errors++;
      $display("FAIL load_timeout: stall still %0b after %0d cycles, required 0", m_stall, n);
    end
  endtask

  task automatic err_req(input logic [31:0] a, input logic [31:0] d, input logic w,
                         input logic r, input logic b, input logic h);
    set_req(a, d, w, r, b, h, 1'b0);
    #1;
    check("err_flag", 32'(m_err), 32'd1);
    check("err_stall", 32'(m_stall), 32'd0);
    check("err_rdata", m_rdata, last_exp);
  endtask

  // Monitor: a falling stall marks the DONE cycle; compare against the scoreboard.
  initial begin
    int   run;
    logic prev;
    exp_t e;
    run  = 0;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        run  = 0;
        prev = 1'b0;
      end else if (m_stall) begin
        run++;
        prev = 1'b1;
      end else if (prev) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: rdata %h with empty scoreboard", m_rdata);
        end else begin
          e = sbq.pop_front();
          check($sformatf("load%0d_rdata", e.id), m_rdata, e.data);
          check($sformatf("load%0d_stall_len", e.id), 32'(run), 32'(e.stall));
        end
        run  = 0;
        prev = 1'b0;
      end
    end
  end

  initial begin
    rst = 1'b1; sel = 1'b0;
    addr = 32'd0; wdata = 32'd0; wr = 1'b0; rd = 1'b0; rdu = 1'b0; bt = 1'b0; hw = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall0", 32'(bus0.o_dmem_stall), 32'd0);
    check("rst_rdata0", bus0.o_dmem_rdata, 32'd0);
    check("rst_err0", 32'(bus0.o_dmem_err), 32'd0);
    check("rst_rdata1", bus1.o_dmem_rdata, 32'd0);
    rst = 1'b0;

    // READ_WAIT=1 instance
    store(32'h00, 32'hA5A5A5A5, 1'b0, 1'b0);
    store(32'h10, 32'hDEADBEEF, 1'b0, 1'b0);
    load(32'h13, 1'b1, 1'b0, 1'b1, 32'h000000DE, 2);
    load(32'h13, 1'b1, 1'b0, 1'b0, 32'hFFFFFFDE, 2);
    store(32'h20, 32'h11223344, 1'b0, 1'b0);
    store(32'h22, 32'h00008001, 1'b0, 1'b1);
    load(32'h20, 1'b0, 1'b0, 1'b0, 32'h80013344, 2);
    load(32'h22, 1'b0, 1'b1, 1'b0, 32'hFFFF8001, 2);
    load(32'h22, 1'b0, 1'b1, 1'b1, 32'h00008001, 2);
    load(32'h20, 1'b1, 1'b0, 1'b0, 32'h00000044, 2);
    load(32'h20, 1'b0, 1'b1, 1'b0, 32'h00003344, 2);
    load(32'h23, 1'b1, 1'b1, 1'b0, 32'hFFFFFF80, 2);
    err_req(32'h06, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    err_req(32'h01, 32'h0000FFFF, 1'b1, 1'b0, 1'b0, 1'b1);
    err_req(32'h00, 32'h12345678, 1'b1, 1'b1, 1'b0, 1'b0);
    load(32'h00, 1'b0, 1'b0, 1'b0, 32'hA5A5A5A5, 2);
    store(32'h11, 32'h0000007F, 1'b1, 1'b0);
    load(32'h10, 1'b0, 1'b0, 1'b0, 32'hDEAD7FEF, 2);
    store(32'h1008, 32'h5A5A5A5A, 1'b0, 1'b0);
    load(32'h08, 1'b0, 1'b0, 1'b0, 32'h5A5A5A5A, 2);

    // Reset in WAIT aborts the load; storage survives.
    store(32'h40, 32'hCAFEF00D, 1'b0, 1'b0);
    set_req(32'h40, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    check("wait_stall", 32'(m_stall), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_wait_stall", 32'(m_stall), 32'd0);
    check("rst_wait_rdata", m_rdata, 32'd0);
    addr = 32'd0; rd = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    load(32'h40, 1'b0, 1'b0, 1'b0, 32'hCAFEF00D, 2);

    // READ_WAIT=0 instance
    idle();
    sel = 1'b1;
    store(32'h00, 32'h01020304, 1'b0, 1'b0);
    store(32'h04, 32'h8899AABB, 1'b0, 1'b0);
    load(32'h00, 1'b0, 1'b0, 1'b0, 32'h01020304, 1);
    load(32'h04, 1'b0, 1'b0, 1'b0, 32'h8899AABB, 1);
    load(32'h07, 1'b1, 1'b0, 1'b0, 32'hFFFFFF88, 1);
    load(32'h06, 1'b0, 1'b1, 1'b1, 32'h00008899, 1);
    idle();
    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, storage depth in 32-bit words (power of two).
REQ-002 Parameter READ_WAIT, default 1, extra wait cycles per load (0..15).
REQ-003 i_clk  input  1  sole clock; all state changes on rising edge.
REQ-004 i_rst  input  1  asynchronous, active-high reset.
REQ-005 i_dmem_addr  input  32  byte address from the pipeline memory stage.
REQ-006 i_dmem_wdata  input  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
REQ-007 i_dmem_write  input  1  store request.
REQ-008 i_dmem_read  input  1  load request.
REQ-009 i_dmem_rdu  input  1  load zero-extends when 1, sign-extends when 0.
REQ-010 i_dmem_byte  input  1  byte-sized access.
REQ-011 i_dmem_hwrd  input  1  halfword-sized access; neither byte nor hwrd means word.
REQ-012 o_dmem_rdata  output  32  extended load data, valid in the DONE cycle.
REQ-013 o_dmem_stall  output  1  initiator holds all request inputs stable while 1.
REQ-014 o_dmem_err  output  1  misaligned access, or read and write asserted together.

Function
REQ-015 Storage word index SHALL be i_dmem_addr[log2(DEPTH_WORDS)+1:2], with upper address bits ignored, so out-of-range addresses wrap.
REQ-016 Alignment rule SHALL be: halfword requires addr[0]=0; word requires addr[1:0]=0; byte is always aligned.
REQ-017 If i_dmem_byte and i_dmem_hwrd are both 1, the access SHALL be treated as byte.
REQ-018 FSM SHALL have three states: IDLE, WAIT, DONE.
REQ-019 Load handling: IDLE with aligned read, no write -> WAIT with counter=READ_WAIT-1 if READ_WAIT>0, else -> DONE.
REQ-020 WAIT SHALL decrement the counter each cycle and go to DONE in the cycle after the counter reaches 0.
REQ-021 DONE -> IDLE unconditionally.
REQ-022 o_dmem_stall SHALL be 1 in the IDLE accept cycle and in WAIT, and 0 in DONE and otherwise.
REQ-023 Total stall for a load SHALL be READ_WAIT+1 cycles, with data presented on the following (DONE) cycle.
REQ-024 Array SHALL be read into a register on entry to DONE; byte lane = addr[1:0]; halfword lane = addr[1]; extension per i_dmem_rdu.
REQ-025 o_dmem_rdata SHALL hold its last value outside DONE.
REQ-026 Store handling: in IDLE, an aligned write with no read SHALL commit at the same clock edge with no stall.
REQ-027 Stores SHALL use byte-lane enables: byte replicated to all lanes, one lane enabled; halfword to lanes {1,0} or {3,2}; word to all four lanes.
REQ-028 o_dmem_err SHALL be combinational from the current inputs and asserted only in IDLE.
REQ-029 Errored requests SHALL perform no array write, cause no stall, and leave o_dmem_rdata unchanged.
REQ-030 A store followed immediately by a load to the same word SHALL return the stored data (write-first).

Reset
REQ-031 i_rst SHALL force the FSM to IDLE, the counter to 0, o_dmem_rdata to 0, and o_dmem_stall to 0 immediately and asynchronously.
REQ-032 Reset during WAIT or DONE SHALL abort the load with no data delivered.
REQ-033 Array contents SHALL NOT be cleared by reset.

Structure
REQ-034 Package dmem_pkg SHALL hold the state enum (IDLE/WAIT/DONE), the access-size enum (BYTE/HWRD/WORD), and the lane-enable helper function.
REQ-035 Sub-module dmem_ram SHALL be DEPTH_WORDS x 32, with one port, 4 byte-enables, synchronous write, and synchronous read.
REQ-036 FSM, alignment check, and load extension SHALL reside in dmem_responder.

Verification
REQ-037 Store word 0xDEADBEEF @0x10, then lbu @0x13 -> 0x000000DE; lb @0x13 -> 0xFFFFFFDE; stall=1 for exactly 2 cycles (READ_WAIT=1).
REQ-038 Store halfword 0x8001 @0x22 over word 0x11223344 @0x20 -> lw @0x20 = 0x80013344; lh @0x22 = 0xFFFF8001; lhu = 0x00008001.
REQ-039 lw @0x06 and sh @0x01 -> err=1, stall=0, array unchanged, rdata unchanged; read+write together @0x0 -> err=1, no write.
REQ-040 READ_WAIT=0: lw @0x0 -> stall for 1 cycle, rdata valid next cycle; back-to-back loads each stall 1 cycle.
REQ-041 Assert i_rst in a WAIT cycle -> stall=0 and rdata=0 immediately; earlier-stored 0xCAFEF00D still reads back after release.
REQ-042 sw 0x5A5A5A5A @(DEPTH_WORDS*4 + 0x8) -> lw @0x8 returns 0x5A5A5A5A (address wrap).
